// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter with TX FIFO, build with UART_TX_PARITY_EN for even parity
module uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_i,
  input  logic [31:0] di_i,
  input  logic [3:0]  m_i,
  input  logic        we_i,
  output logic [31:0] do_o,
  output logic        hit_o,
  output logic        tx_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [6:0]    count_q, count_d;
  logic [15:0]   div_q, bcnt_q;
  logic [7:0]    sh_q, head;
  logic [2:0]    bit_q;
  logic          ovf_q, par_q, tx_q;
  logic          wr_en, push_req, push, pop, full, empty, bit_end, ovf_clr;
  logic [31:0]   status;
  logic          unused_ok;
  assign hit_o    = a_i[31:4] == BASE_ADDR[31:4];
  assign wr_en    = we_i & hit_o;
  assign push_req = wr_en & (a_i[3:2] == 2'd0) & m_i[0];
  assign ovf_clr  = wr_en & (a_i[3:2] == 2'd1) & m_i[0] & di_i[3];
  assign full     = count_q == 7'(FIFO_DEPTH);
  assign empty    = count_q == 7'd0;
  assign push     = push_req & ~full;
  assign bit_end  = bcnt_q == 16'd0;
  // a pop feeds a new frame either from idle or back-to-back at the end of a stop bit
  assign pop      = ~empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));
  assign count_d  = count_q + 7'(push) - 7'(pop);
  assign head     = mem_q[rd_q];
  assign status   = {17'd0, count_q, 3'd0, PAR_EN, ovf_q, state_q != IDLE, empty, full};
  assign do_o     = !hit_o ? 32'd0 : (a_i[3:2] == 2'd1) ? status : (a_i[3:2] == 2'd2) ? {16'd0, div_q} : 32'd0;
  assign tx_o     = tx_q;
  assign unused_ok = ^{a_i[1:0], di_i[31:16], m_i[3:2]};
  // FIFO storage, no reset needed since occupancy tracks validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= di_i[7:0];
  end
  // FIFO pointers, sticky overflow and baud divisor register
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DEFAULT_DIV;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      count_q <= count_d;
      ovf_q   <= (push_req & full) | (ovf_q & ~ovf_clr);
      if (wr_en & (a_i[3:2] == 2'd2) & m_i[0]) div_q[7:0]  <= di_i[7:0];
      if (wr_en & (a_i[3:2] == 2'd2) & m_i[1]) div_q[15:8] <= di_i[15:8];
    end
  end
  // frame state machine; the bit counter reloads from the live divisor at every bit boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      bcnt_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      bcnt_q <= (bit_end || state_q == IDLE) ? div_q : bcnt_q - 16'd1;
      if (pop) begin
        state_q <= START;
        tx_q    <= 1'b0;
        sh_q    <= head;
        par_q   <= ^head;
      end else if (bit_end) begin
        case (state_q)
          START: begin
            state_q <= DATA;
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
            bit_q   <= 3'd0;
          end
          DATA: begin
            if (bit_q == 3'd7) begin
              if (PAR_EN) state_q <= PARITY;
              else state_q <= STOP;
              tx_q <= PAR_EN ? par_q : 1'b1;
            end else begin
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
              bit_q <= bit_q + 3'd1;
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: state_q <= IDLE;
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: directed bench for uart_tx_periph, honours UART_TX_PARITY_EN
module tb_uart_tx_periph;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] PB = 32'h10;
  localparam int          NB = 11;
`else
  localparam logic [31:0] PB = 32'h0;
  localparam int          NB = 10;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0, di = '0;
  logic [3:0]  m = '0;
  logic        we = 1'b0;
  logic [31:0] do_o;
  logic        hit, tx;
  int          total = 0, passed = 0, failed = 0;
  uart_tx_periph dut (
    .clk(clk), .reset(reset), .a_i(a), .di_i(di), .m_i(m), .we_i(we),
    .do_o(do_o), .hit_o(hit), .tx_o(tx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    a = addr; di = data; m = mask; we = 1'b1;
    step();
    we = 1'b0; m = '0; a = '0;
  endtask
  task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a = addr; we = 1'b0;
    #1;
    chk(tag, do_o, exp);
    a = '0;
  endtask
  task automatic expect_bit(input logic val, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, {31'd0, tx}, {31'd0, val});
    end
  endtask
  // line model: start, data LSB first, optional even parity, stop
  task automatic check_frame(input logic [7:0] b, input int per, input int skip, input string tag);
    logic [10:0] bits;
    int s;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    bits[9]  = ^b;
    bits[10] = 1'b1;
`else
    bits[9]  = 1'b1;
`endif
    s = 0;
    for (int k = 0; k < NB; k++)
      for (int c = 0; c < per; c++) begin
        if (s >= skip) begin
          step();
          chk(tag, {31'd0, tx}, {31'd0, bits[k]});
        end
        s++;
      end
  endtask
  initial begin
    logic [7:0] b55;
    b55 = 8'h55;
    repeat (2) step();
    reset = 1'b1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk_rd("reset_status", BASE + 32'h4, 32'h2 | PB);
    chk_rd("reset_div", BASE + 32'h8, 32'h363);
    // single frame at DIV=3
    wr(BASE + 32'h8, 32'd3, 4'b0011);
    chk_rd("div3", BASE + 32'h8, 32'd3);
    wr(BASE, 32'hA5, 4'b0001);
    chk("a5_tx_before_start", {31'd0, tx}, 32'd1);
    chk_rd("a5_count1", BASE + 32'h4, 32'h100 | PB);
    check_frame(8'hA5, 4, 0, "frame_a5");
    step();
    chk("a5_idle_tx", {31'd0, tx}, 32'd1);
    chk_rd("a5_busy_clear", BASE + 32'h4, 32'h2 | PB);
    // nine back-to-back pushes, first pop frees a slot
    for (int i = 0; i < 9; i++) wr(BASE, 32'h10 + i, 4'b0001);
    chk_rd("fifo_full8", BASE + 32'h4, 32'h805 | PB);
    wr(BASE, 32'hEE, 4'b0001);
    chk_rd("fifo_overflow", BASE + 32'h4, 32'h80D | PB);
    wr(BASE + 32'h4, 32'h8, 4'b0001);
    chk_rd("ovf_w1c", BASE + 32'h4, 32'h805 | PB);
    // reset mid-frame
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midreset_tx", {31'd0, tx}, 32'd1);
    chk_rd("midreset_status", BASE + 32'h4, 32'h2 | PB);
    chk_rd("midreset_div", BASE + 32'h8, 32'h363);
    // abutting frames at DIV=0
    wr(BASE + 32'h8, 32'd0, 4'b0011);
    wr(BASE, 32'hFF, 4'b0001);
    wr(BASE, 32'h00, 4'b0001);
    chk("abut_start1", {31'd0, tx}, 32'd0);
    check_frame(8'hFF, 1, 1, "abut_ff");
    check_frame(8'h00, 1, 0, "abut_00");
    step();
    chk("abut_idle_tx", {31'd0, tx}, 32'd1);
    chk_rd("abut_status", BASE + 32'h4, 32'h2 | PB);
    // divisor change 3 -> 7 during data bit 0
    wr(BASE + 32'h8, 32'd3, 4'b0011);
    wr(BASE, 32'h55, 4'b0001);
    chk("div_pre", {31'd0, tx}, 32'd1);
    expect_bit(1'b0, 4, "div_start");
    expect_bit(1'b1, 1, "div_bit0a");
    wr(BASE + 32'h8, 32'd7, 4'b0011);
    chk("div_bit0b", {31'd0, tx}, 32'd1);
    expect_bit(1'b1, 2, "div_bit0c");
    for (int k = 1; k < 8; k++) expect_bit(b55[k], 8, "div_data8");
`ifdef UART_TX_PARITY_EN
    expect_bit(1'b0, 8, "div_parity");
`endif
    expect_bit(1'b1, 8, "div_stop");
    step();
    chk_rd("div_done", BASE + 32'h4, 32'h2 | PB);
    // 0x07 frame at DIV=0, hand-written line pattern
    wr(BASE + 32'h8, 32'd0, 4'b0011);
    wr(BASE, 32'h07, 4'b0001);
    expect_bit(1'b0, 1, "x07_start");
    expect_bit(1'b1, 3, "x07_ones");
    expect_bit(1'b0, 5, "x07_zeros");
`ifdef UART_TX_PARITY_EN
    expect_bit(1'b1, 1, "x07_parity");
`endif
    expect_bit(1'b1, 1, "x07_stop");
    step();
    chk_rd("x07_done", BASE + 32'h4, 32'h2 | PB);
    // address decode and byte masks
    chk_rd("reserved_rd", BASE + 32'hC, 32'd0);
    a = BASE + 32'hC;
    #1;
    chk("reserved_hit", {31'd0, hit}, 32'd1);
    wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    chk_rd("reserved_wr_ignored", BASE + 32'h8, 32'd0);
    a = BASE + 32'h10;
    #1;
    chk("outside_hit", {31'd0, hit}, 32'd0);
    chk_rd("outside_do", BASE + 32'h10, 32'd0);
    chk_rd("txdata_rd", BASE, 32'd0);
    chk_rd("status_unaligned", BASE + 32'h6, 32'h2 | PB);
    wr(BASE + 32'h8, 32'h1234, 4'b0010);
    chk_rd("div_mask_hi", BASE + 32'h8, 32'h1200);
    wr(BASE + 32'h8, 32'hAB56, 4'b0001);
    chk_rd("div_mask_lo", BASE + 32'h8, 32'h1256);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter acting as a responder on the CPU data bus, beside the RAM. The CPU writes bytes into a small TX FIFO through ordinary store instructions, then polls status through loads. A baud-rate counter and frame state machine serialise each byte onto a single `tx` line: start bit, 8 data bits LSB first, optional parity bit, stop bit. The top-level read mux uses `hit` to select this block's `do` over RAM read data.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: word-aligned base of the 16-byte register window.
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, 2..64.
- `DEFAULT_DIV`, default 16'd867: reset value of the baud divisor; bit period = DIV+1 clocks.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `a`  in  32  data-bus byte address.
- `di`  in  32  data-bus write data.
- `m`  in  4  byte write mask; `m[0]` covers `di[7:0]`.
- `we`  in  1  data-bus write enable.
- `do`  out  32  read data, combinational from `a`; 0 when `hit`=0.
- `hit`  out  1  combinational; 1 when `a[31:4]` == `BASE_ADDR[31:4]`.
- `tx`  out  1  serial output, registered, idles high.

## Operation
- Register map, offset `a[3:2]`; `a[1:0]` ignored:
  - 0x0 TXDATA: a write with `m[0]`=1 pushes `di[7:0]`. Reads return 0.
  - 0x4 STATUS: read only, except W1C. bit0 full; bit1 empty; bit2 busy (state≠IDLE); bit3 overflow (sticky); bits[14:8] FIFO count. Writing `m[0]`=1 with `di[3]`=1 clears overflow.
  - 0x8 DIV: bits[15:0] hold the baud divisor. The write honours `m[1:0]` per byte.
  - 0xC: reserved; reads 0, writes ignored.
- Push when full: the byte is dropped and overflow is set. Fullness is judged on occupancy before any same-cycle pop.
- FSM states and transitions:
  - IDLE→START when the FIFO is non-empty; the head is popped into the shift register on that edge.
  - START→DATA after 1 bit period.
  - DATA spans 8 bit periods, LSB first, then goes to PARITY if compiled in, otherwise STOP.
  - STOP→IDLE after 1 bit period.
  - If the FIFO is non-empty at STOP end, the FSM goes straight STOP→START instead, with no idle bit between frames.
- Bit counter:
  - Counts from DIV down to 0.
  - Reloads from the current DIV register at every bit boundary.
  - A DIV write mid-frame affects the next bit, never the bit in progress.
- DIV=0 is legal: 1 clock per bit.
- Reset values: `tx`=1, FIFO empty, overflow=0, DIV=`DEFAULT_DIV`, state IDLE. Reset mid-frame aborts the frame immediately; `tx`=1 on the following cycle.

## Timing
- A write is committed at the rising edge where `we`=1 and `hit`=1.
- The FIFO count and STATUS reflect the write from that edge onward.
- From idle, the write at edge N makes the FSM enter START at edge N+1; `tx` falls at edge N+1.
- Frame length is 10×(DIV+1) clocks, or 11×(DIV+1) with parity.
- busy drops at the edge that ends STOP with the FIFO empty.
- `do` and `hit` have zero latency (combinational), matching RAM read timing on the data bus.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state follows DATA and sends even parity (XOR of the 8 data bits). STATUS bit4 reads 1.
  - Undefined: there is no PARITY state, frames are 10 bits, and STATUS bit4 reads 0.

## Test plan
- Reset with DIV write 3, then push 0xA5:
  - `tx` falls 1 cycle after the write.
  - The line then carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy clears 40 cycles after START.
- Push 9 bytes back-to-back with `FIFO_DEPTH`=8 while idle:
  - The first pop makes room, so the 9th byte is accepted.
  - Then fill to count 8 and push once more: overflow=1 and count stays 8.
  - A W1C write of 0x8 to STATUS clears overflow.
- Two bytes queued, DIV=0: the frames abut; STOP is 1 cycle high, then START, with no extra idle cycle.
- Change DIV from 3 to 7 mid-DATA: the current bit keeps 4 cycles and all subsequent bits last 8 cycles.
- Assert `reset` low mid-frame for 1 cycle:
  - `tx`=1 next cycle, FIFO empty, DIV=`DEFAULT_DIV`.
  - STATUS reads 0x0000_0002 (bit4 set if parity is compiled in).
- With `UART_TX_PARITY_EN`, push 0x07: the parity bit is 1 and the frame is 11 bit periods. Reads at BASE+0xC return 0; `hit`=0 at BASE+0x10.
